// File: rtl/mem_bus_arbiter.sv
// Shares the single-ported memory bus between instruction fetch and load/store, one transaction
// outstanding at a time, MEM first; handles pipeline flushes and bus timeouts.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  input  logic        flush_i,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stallreq_from_if_o,
  output logic        stallreq_from_mem_o,
  output logic        bus_timeout_o
);

  localparam bit         TimeoutEn   = (TIMEOUT_CYC != 0);
  localparam logic [7:0] TimeoutLast = 8'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIfBusy,
    StMemBusy,
    StIfDiscard,
    StMemDiscard
  } state_e;

  state_e      state_q, state_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic owner_mem;
  logic live;
  logic expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    owner_mem   = (state_q == StMemBusy) || (state_q == StMemDiscard);
    // A flush arriving in the completing cycle also discards the result.
    live        = ((state_q == StIfBusy) || (state_q == StMemBusy)) && !flush_i;
    expired     = TimeoutEn && !bus_ack_i && (cnt_q == TimeoutLast);

    unique case (state_q)
      StIdle: begin
        // The done cycle is a dead cycle: nothing is issued while a done flag is up.
        if (!if_done_q && !mem_done_q && !flush_i) begin
          if (mem_req_i) begin
            state_d     = StMemBusy;
            bus_we_d    = mem_we_i;
            bus_sel_d   = mem_sel_i;
            bus_addr_d  = mem_addr_i;
            bus_wdata_d = mem_wdata_i;
            cnt_d       = '0;
          end else if (if_req_i) begin
            state_d     = StIfBusy;
            bus_we_d    = 1'b0;
            bus_sel_d   = 4'hF;
            bus_addr_d  = if_addr_i;
            bus_wdata_d = '0;
            cnt_d       = '0;
          end
        end
      end
      default: begin
        if (bus_ack_i || expired) begin
          state_d   = StIdle;
          timeout_d = !bus_ack_i;
          if (live && owner_mem) begin
            mem_done_d = 1'b1;
            if (!bus_we_q) mem_rdata_d = bus_ack_i ? bus_rdata_i : 32'h0;
          end else if (live) begin
            if_done_d = 1'b1;
            if_data_d = bus_ack_i ? bus_rdata_i : 32'h0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (flush_i && state_q == StIfBusy)  state_d = StIfDiscard;
          if (flush_i && state_q == StMemBusy) state_d = StMemDiscard;
        end
      end
    endcase
  end

  always_comb begin
    bus_stb_o           = (state_q != StIdle);
    bus_we_o            = bus_we_q;
    bus_sel_o           = bus_sel_q;
    bus_addr_o          = bus_addr_q;
    bus_wdata_o         = bus_wdata_q;
    if_data_o           = if_data_q;
    mem_rdata_o         = mem_rdata_q;
    bus_timeout_o       = timeout_q;
    stallreq_from_if_o  = if_req_i & ~if_done_q;
    stallreq_from_mem_o = mem_req_i & ~mem_done_q;
  end

endmodule
